// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel pattern out MSB-first, optionally repeated,
// and runs a Moore "two-or-more consecutive ones" model on the transmitted bits.
module serial_pattern_tx #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [REPEAT_W-1:0] in_repeat,
    output logic                tx_bit,
    output logic                tx_active,
    output logic                done,
    output logic                exp_det,
    output logic [7:0]          det_count,
    output logic [1:0]          fsm_state,
    output logic [1:0]          model_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M0 = 2'd0,
        M1 = 2'd1,
        M2 = 2'd2
    } model_t;

    state_t                state_q, state_d;
    model_t                model_q, model_d;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [WIDTH-1:0]      pattern_q, pattern_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [REPEAT_W-1:0]   rep_left_q, rep_left_d;
    logic                  tx_bit_q, tx_bit_d;
    logic                  done_q, done_d;
    logic [7:0]            det_count_q, det_count_d;
    logic                  handshake;
    logic                  det_rise;

    // Handshake: a transfer happens on a rising edge where in_valid and in_ready are both
    // high; in_ready is high only in IDLE, and in_data/in_repeat are sampled only then.
    assign handshake = in_valid && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pattern_d  = pattern_q;
        bit_cnt_d  = bit_cnt_q;
        rep_left_d = rep_left_q;
        tx_bit_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d    = SHIFT;
                    pattern_d  = in_data;
                    tx_bit_d   = in_data[WIDTH-1];
                    shreg_d    = {in_data[WIDTH-2:0], 1'b0};
                    bit_cnt_d  = LAST_BIT;
                    rep_left_d = in_repeat;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (rep_left_q != '0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tx_bit_d  = shreg_q[WIDTH-1];
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            GAP: begin
                // The gap cycle itself drives zero; the reload puts the next copy's MSB
                // on the line in the following cycle.
                state_d    = SHIFT;
                rep_left_d = rep_left_q - 1'b1;
                tx_bit_d   = pattern_q[WIDTH-1];
                shreg_d    = {pattern_q[WIDTH-2:0], 1'b0};
                bit_cnt_d  = LAST_BIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        model_d = M0;
        case (model_q)
            M0:      model_d = tx_bit_q ? M1 : M0;
            M1:      model_d = tx_bit_q ? M2 : M0;
            M2:      model_d = tx_bit_q ? M2 : M0;
            default: model_d = M0;
        endcase
    end

    // Counting on the model's next state keeps det_count aligned with exp_det.
    assign det_rise = (model_d == M2) && (model_q != M2);

    always_comb begin
        det_count_d = det_count_q;
        if (handshake) begin
            det_count_d = 8'd0;
        end else if (det_rise && (det_count_q != 8'hFF)) begin
            det_count_d = det_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            model_q     <= M0;
            shreg_q     <= '0;
            pattern_q   <= '0;
            bit_cnt_q   <= '0;
            rep_left_q  <= '0;
            tx_bit_q    <= 1'b0;
            done_q      <= 1'b0;
            det_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            model_q     <= model_d;
            shreg_q     <= shreg_d;
            pattern_q   <= pattern_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_left_q  <= rep_left_d;
            tx_bit_q    <= tx_bit_d;
            done_q      <= done_d;
            det_count_q <= det_count_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign tx_active   = (state_q != IDLE);
    assign tx_bit      = tx_bit_q;
    assign done        = done_q;
    assign exp_det     = (model_q == M2);
    assign det_count   = det_count_q;
    assign fsm_state   = state_q;
    assign model_state = model_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: table-driven frames, hand-written corner
// sequences and random frames checked against a bit-stream reference model.
module tb_serial_pattern_tx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_repeat;
    logic       tx_bit;
    logic       tx_active;
    logic       done;
    logic       exp_det;
    logic [7:0] det_count;
    logic [1:0] fsm_state;
    logic [1:0] model_state;

    int n_checks = 0;
    int n_fail   = 0;

    serial_pattern_tx #(.WIDTH(8), .REPEAT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_repeat  (in_repeat),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .done       (done),
        .exp_det    (exp_det),
        .det_count  (det_count),
        .fsm_state  (fsm_state),
        .model_state(model_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input logic [7:0] held_cnt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx_bit", tx_bit, 0);
            check("idle_active", tx_active, 0);
            check("idle_ready", in_ready, 1);
            check("idle_done", done, 0);
            check("idle_exp_det", exp_det, 0);
            check("idle_det_count", det_count, held_cnt);
        end
    endtask

    // Called in the negedge phase with in_ready expected high. The reference builds the
    // expected serial stream, then exp_det(c) = tx(c-1) & tx(c-2) and det_count counts
    // rising edges of that signal since the handshake.
    task automatic run_frame(input logic [7:0] data, input logic [3:0] rep, input bit hold,
                             output int active_cnt, output logic [7:0] final_cnt);
        logic exp_q[$];
        int   len;
        logic t1, t2, e, e_prev, txe;
        int   cnt;
        exp_q = {};
        for (int cp = 0; cp <= int'(rep); cp++) begin
            if (cp > 0) exp_q.push_back(1'b0);
            for (int b = 7; b >= 0; b--) exp_q.push_back(data[b]);
        end
        len = exp_q.size();
        t1 = 1'b0; t2 = 1'b0; e_prev = 1'b0; cnt = 0; active_cnt = 0;

        check("pre_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = data;
        in_repeat = rep;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;

        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            txe = (c <= len) ? exp_q[c-1] : 1'b0;
            e = t1 & t2;
            if (e && !e_prev && cnt < 255) cnt++;
            check($sformatf("tx_bit d=%h r=%0d c=%0d", data, rep, c), tx_bit, txe);
            check($sformatf("exp_det d=%h r=%0d c=%0d", data, rep, c), exp_det, e);
            check($sformatf("det_count d=%h r=%0d c=%0d", data, rep, c), det_count, cnt);
            check($sformatf("tx_active d=%h r=%0d c=%0d", data, rep, c), tx_active, c <= len);
            check($sformatf("in_ready d=%h r=%0d c=%0d", data, rep, c), in_ready, c > len);
            check($sformatf("done d=%h r=%0d c=%0d", data, rep, c), done, c > len);
            if (tx_active) active_cnt++;
            e_prev = e; t2 = t1; t1 = txe;
            if (hold) begin
                in_data   = 8'($urandom);
                in_repeat = 4'($urandom);
            end
        end
        final_cnt = det_count;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [3:0] rep;
        int         exp_len;
        int         exp_cnt;
    } vec_t;

    vec_t       vecs[6];
    int         act_len;
    logic [7:0] fin_cnt;

    initial begin
        vecs[0] = '{data: 8'hB6, rep: 4'd0,  exp_len: 8,   exp_cnt: 2};
        vecs[1] = '{data: 8'hFF, rep: 4'd1,  exp_len: 17,  exp_cnt: 2};
        vecs[2] = '{data: 8'h00, rep: 4'd0,  exp_len: 8,   exp_cnt: 0};
        vecs[3] = '{data: 8'h55, rep: 4'd0,  exp_len: 8,   exp_cnt: 0};
        vecs[4] = '{data: 8'hAA, rep: 4'd15, exp_len: 143, exp_cnt: 0};
        vecs[5] = '{data: 8'hCC, rep: 4'd15, exp_len: 143, exp_cnt: 32};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_repeat = 4'd0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_tx_bit", tx_bit, 0);
        check("rst_active", tx_active, 0);
        check("rst_done", done, 0);
        check("rst_exp_det", exp_det, 0);
        check("rst_det_count", det_count, 0);
        rst = 1'b1;
        idle_cycles(2, 8'd0);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].rep, 1'b0, act_len, fin_cnt);
            check($sformatf("vec%0d_active_len", i), act_len, vecs[i].exp_len);
            check($sformatf("vec%0d_final_count", i), fin_cnt, vecs[i].exp_cnt);
            idle_cycles(2, fin_cnt);
        end

        // back-to-back frames: second handshake lands in the done cycle
        run_frame(8'hB6, 4'd0, 1'b0, act_len, fin_cnt);
        run_frame(8'hFF, 4'd1, 1'b0, act_len, fin_cnt);
        check("b2b_final_count", fin_cnt, 2);
        idle_cycles(1, fin_cnt);

        // in_valid held high with changing data during a frame
        run_frame(8'h3C, 4'd1, 1'b1, act_len, fin_cnt);
        check("hold_final_count", fin_cnt, 2);
        run_frame(8'hE7, 4'd0, 1'b0, act_len, fin_cnt);
        check("hold_second_count", fin_cnt, 2);
        idle_cycles(1, fin_cnt);

        // reset in cycle 4 of an FF, R=3 frame
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_repeat = 4'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("abort_tx_before", tx_bit, 1);
        check("abort_exp_det_before", exp_det, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_ready", in_ready, 1);
        check("abort_tx_bit", tx_bit, 0);
        check("abort_active", tx_active, 0);
        check("abort_done", done, 0);
        check("abort_exp_det", exp_det, 0);
        check("abort_det_count", det_count, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("post_abort_done", done, 0);
            check("post_abort_active", tx_active, 0);
        end
        run_frame(8'hB6, 4'd0, 1'b0, act_len, fin_cnt);
        check("post_abort_count", fin_cnt, 2);
        idle_cycles(1, fin_cnt);

        // random frames against the reference model
        for (int i = 0; i < 20; i++) begin
            run_frame(8'($urandom), 4'($urandom_range(0, 3)), 1'b0, act_len, fin_cnt);
            idle_cycles($urandom_range(0, 2), fin_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter for the sequence-detector path. It accepts a parallel pattern through a valid/ready handshake and shifts it out MSB-first, one bit per clock, optionally repeated with a one-cycle zero gap between copies. An internal Moore model of the "two-or-more consecutive ones" detector runs on the transmitted bits. Its output and hit count give the expected detector response for cycle-exact comparison against the detector it drives.

## Interface
Parameters:
- WIDTH, 8, pattern length in bits (≥2)
- REPEAT_W, 4, width of repeat field

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pattern offered
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  WIDTH  pattern, bit WIDTH-1 transmitted first
- in_repeat  in  REPEAT_W  extra copies after the first (0 = send once)
- tx_bit  out  1  registered serial output, feeds detector In
- tx_active  out  1  high in SHIFT and GAP
- done  out  1  one-cycle pulse when a frame completes
- exp_det  out  1  expected detector output (model in its "seen ≥2 ones" state)
- det_count  out  8  rising edges of exp_det in the current frame, saturating at 255

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, tx_bit=0.
  - On in_valid&in_ready: latch in_data into the shift register and in_repeat into rep_left, set bit_cnt=WIDTH-1, clear det_count and done, go to SHIFT.
- SHIFT:
  - tx_bit = current MSB; shift left each cycle; decrement bit_cnt.
  - At bit_cnt==0: if rep_left>0, go to GAP. Otherwise go to IDLE and pulse done.
- GAP:
  - tx_bit=0 for exactly one cycle; decrement rep_left; reload the latched pattern; go to SHIFT.
- in_valid during SHIFT/GAP is ignored, with no side effects. in_data/in_repeat are sampled only at handshake.
- Detector model:
  - 3-state Moore FSM (M0, M1, M2), updated every edge from tx_bit.
  - M0: 1→M1, 0→M0.
  - M1: 1→M2, 0→M0.
  - M2: 1→M2, 0→M0.
  - exp_det = (model==M2). The model runs in every state, including IDLE.
- det_count increments on each cycle where exp_det=1 and its previous value was 0. It holds at 255 and is cleared on handshake.
- Reset (any time, including mid-frame): state IDLE, tx_bit=0, tx_active=0, done=0, exp_det=0 (model M0), det_count=0, in_ready=1. No done is emitted for an aborted frame.

## Timing
- Handshake at edge E0. Pattern bit WIDTH-1-k is on tx_bit during cycle k+1 after E0 (k=0..WIDTH-1).
- Frame length with in_repeat=R: (R+1)·WIDTH + R cycles of tx_active.
- done and in_ready are high in the first cycle after the last bit. A new handshake is allowed in that cycle, which gives back-to-back frames with one idle (tx_bit=0) cycle between them.
- exp_det lags tx_bit by one cycle: the model consumes the bit at the edge ending that bit's cycle. This is identical to a detector on the same clk/rst.
- The final bit's effect on exp_det and det_count is visible in the done cycle. det_count is stable from the done cycle until the next handshake.

## Test plan
- in_data=8'hB6, R=0:
  - tx_bit cycles 1–8 = 1,0,1,1,0,1,1,0.
  - exp_det high only in cycles 5 and 8.
  - done in cycle 9; det_count=2.
- in_data=8'hFF, R=1:
  - tx_bit=1 in cycles 1–8, 0 in cycle 9, 1 in cycles 10–17.
  - exp_det high in cycles 3–9 and 12–18.
  - done in cycle 18; det_count=2.
- in_data=8'h00 and 8'h55, R=0: exp_det never high, det_count=0, done in cycle 9.
- in_valid held high with changing in_data during a frame: in_ready=0 throughout and the frame is unchanged. The second handshake occurs in the done cycle, and its first bit appears in the next cycle.
- rst asserted in cycle 4 of an 8'hFF, R=3 frame:
  - All outputs immediately return to their reset values and no done is emitted.
  - After release, in_ready=1 and a new frame transmits normally.
- 8'hAA with R=15: 16 copies separated by gaps, 143 active cycles, det_count=0. Then 8'hCC with R=15: det_count=32.
